uart_host_if: RTL

Host-side bus master for the CoreUART parallel interface. It buffers outbound bytes in a TX FIFO and writes them into the UART whenever TXRDY is high. It reads received bytes out of the UART on RXRDY into an RX FIFO for the fabric logic. It sits between the test firmware datapath and the UART instance and owns the CSN/WEN/OEN strobes, so nothing else drives them.

---
 rtl/uart_host_if.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/uart_host_if.sv
// Host-side bus master for the CoreUART parallel port: TX/RX byte FIFOs plus strobe sequencer.
// Optional UART_HOST_ERR_CAPTURE_EN: sticky error flags and discard of bytes with framing/parity errors.
module uart_host_if #(
    parameter int FIFO_DEPTH = 16
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic [7:0] TX_DATA,
    input  logic       TX_WR,
    output logic       TX_FULL,
    output logic [7:0] RX_DATA,
    input  logic       RX_RD,
    output logic       RX_EMPTY,
    output logic [2:0] ERR_FLAGS,
    input  logic       ERR_CLR,
    output logic [7:0] U_DATA_OUT,
    input  logic [7:0] U_DATA_IN,
    output logic       U_CSN,
    output logic       U_WEN,
    output logic       U_OEN,
    input  logic       U_TXRDY,
    input  logic       U_RXRDY,
    input  logic       U_PARITY_ERR,
    input  logic       U_FRAMING_ERR,
    input  logic       U_OVERFLOW
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_WR_STB = 3'd1;
    localparam logic [2:0] S_WR_REL = 3'd2;
    localparam logic [2:0] S_RD_STB = 3'd3;
    localparam logic [2:0] S_RD_CAP = 3'd4;
    localparam logic [2:0] S_RD_REL = 3'd5;

    logic [2:0]    state_q, state_d;
    logic [7:0]    tx_mem [FIFO_DEPTH];
    logic [7:0]    rx_mem [FIFO_DEPTH];
    logic [AW-1:0] tx_wr_q, tx_rd_q, rx_wr_q, rx_rd_q, rx_rd_d;
    logic [CW-1:0] tx_cnt_q, tx_cnt_d, rx_cnt_q, rx_cnt_d;
    logic          tx_push, tx_pop, rx_push, rx_pop;
    logic [7:0]    cap_data_q, rx_data_q, rx_data_d, udo_q;
    logic          cap_keep_q, cap_keep_d;
    logic [2:0]    err_q, err_d;
    logic          tx_full_q, rx_empty_q, csn_q, wen_q, oen_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                // Reads win so the UART receive holding register is drained first.
                if (U_RXRDY && rx_cnt_q != FULL_CNT)   state_d = S_RD_STB;
                else if (U_TXRDY && tx_cnt_q != '0)    state_d = S_WR_STB;
            end
            S_WR_STB: state_d = S_WR_REL;
            S_WR_REL: state_d = S_IDLE;
            S_RD_STB: state_d = S_RD_CAP;
            S_RD_CAP: state_d = S_RD_REL;
            S_RD_REL: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    assign tx_push  = TX_WR && (tx_cnt_q != FULL_CNT);
    assign tx_pop   = (state_q == S_WR_STB) && (tx_cnt_q != '0);
    assign rx_push  = (state_q == S_RD_REL) && cap_keep_q && (rx_cnt_q != FULL_CNT);
    assign rx_pop   = RX_RD && (rx_cnt_q != '0);
    assign tx_cnt_d = tx_cnt_q + CW'(tx_push) - CW'(tx_pop);
    assign rx_cnt_d = rx_cnt_q + CW'(rx_push) - CW'(rx_pop);
    assign rx_rd_d  = rx_pop ? rx_rd_q + AW'(1) : rx_rd_q;

    // Registered show-ahead head: a push that lands on the new read pointer bypasses the RAM.
    always_comb begin
        rx_data_d = rx_data_q;
        if (rx_cnt_d != '0)
            rx_data_d = (rx_push && rx_wr_q == rx_rd_d) ? cap_data_q : rx_mem[rx_rd_d];
    end

`ifdef UART_HOST_ERR_CAPTURE_EN
    assign cap_keep_d = !(U_FRAMING_ERR || U_PARITY_ERR);
    always_comb begin
        err_d = ERR_CLR ? 3'b000 : err_q;
        if (state_q == S_RD_CAP)
            err_d = err_d | {U_OVERFLOW, U_FRAMING_ERR, U_PARITY_ERR};
    end
`else
    logic unused_err;
    assign unused_err = ^{ERR_CLR, U_OVERFLOW, U_FRAMING_ERR, U_PARITY_ERR};
    assign cap_keep_d = 1'b1;
    assign err_d      = 3'b000;
`endif

    always_ff @(posedge CLK) begin
        if (tx_push) tx_mem[tx_wr_q] <= TX_DATA;
        if (rx_push) rx_mem[rx_wr_q] <= cap_data_q;
    end

    // Strobes are decoded from the previous state, so each bus phase trails its state by one cycle.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q    <= S_IDLE;
            tx_wr_q    <= '0;
            tx_rd_q    <= '0;
            tx_cnt_q   <= '0;
            rx_wr_q    <= '0;
            rx_rd_q    <= '0;
            rx_cnt_q   <= '0;
            cap_data_q <= 8'h00;
            cap_keep_q <= 1'b0;
            err_q      <= 3'b000;
            rx_data_q  <= 8'h00;
            udo_q      <= 8'h00;
            tx_full_q  <= 1'b0;
            rx_empty_q <= 1'b1;
            csn_q      <= 1'b1;
            wen_q      <= 1'b1;
            oen_q      <= 1'b1;
        end else begin
            state_q    <= state_d;
            if (tx_push) tx_wr_q <= tx_wr_q + AW'(1);
            if (tx_pop)  tx_rd_q <= tx_rd_q + AW'(1);
            if (rx_push) rx_wr_q <= rx_wr_q + AW'(1);
            rx_rd_q    <= rx_rd_d;
            tx_cnt_q   <= tx_cnt_d;
            rx_cnt_q   <= rx_cnt_d;
            if (state_q == S_RD_CAP) begin
                cap_data_q <= U_DATA_IN;
                cap_keep_q <= cap_keep_d;
            end
            if (state_q == S_WR_STB) udo_q <= tx_mem[tx_rd_q];
            err_q      <= err_d;
            rx_data_q  <= rx_data_d;
            tx_full_q  <= (tx_cnt_d == FULL_CNT);
            rx_empty_q <= (rx_cnt_d == '0);
            csn_q      <= !(state_q == S_WR_STB || state_q == S_RD_STB || state_q == S_RD_CAP);
            wen_q      <= !(state_q == S_WR_STB);
            oen_q      <= !(state_q == S_RD_STB || state_q == S_RD_CAP);
        end
    end

    assign TX_FULL    = tx_full_q;
    assign RX_EMPTY   = rx_empty_q;
    assign RX_DATA    = rx_data_q;
    assign ERR_FLAGS  = err_q;
    assign U_DATA_OUT = udo_q;
    assign U_CSN      = csn_q;
    assign U_WEN      = wen_q;
    assign U_OEN      = oen_q;
endmodule
